// File: rtl/sc_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package sc_fifo_pkg;
  localparam int DEF_DW       = 61;
  localparam int DEF_AW       = 3;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 2;
  localparam int DEF_FWFT     = 0;

  // Occupancy runs 0..2^AW inclusive, so it needs one bit more than the address.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/sc_fifo_param_if.sv
// FIFO data/status bundle; master is the producer/consumer side, slave is the FIFO.
interface sc_fifo_param_if
  import sc_fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();
  localparam int CW = count_width(AW);

  // Handshake: a write is taken on a rising edge when we=1 and (full=0 or re=1);
  // a read is taken when re=1 and empty=0. Requests that are not taken are
  // dropped and latch overflow/underflow. There is no back-pressure wait.
  logic [DW-1:0] din;
  logic          we;
  logic          re;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output din, we, re,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, we, re,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sc_fifo_ram.sv
// 2^AW x DW storage: one synchronous write port, one asynchronous read port.
module sc_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sc_fifo_param.sv
// Synchronous FIFO with registered status flags, sticky error bits and optional FWFT read.
module sc_fifo_param
  import sc_fifo_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int FWFT     = DEF_FWFT
) (
  input logic            clk,
  input logic            rst,
  input logic            clr,
  sc_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = count_width(AW);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sc_fifo_param: AF_LEVEL out of range 1..2^AW");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sc_fifo_param: AE_LEVEL out of range 0..2^AW-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sc_fifo_param: FWFT must be 0 or 1");
  end

  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic          wa, ra, flush;
  logic [DW-1:0] rd_data;

  // Acceptance looks only at registered flags, so a read frees a slot for a same-edge write.
  assign flush = !rst || clr;
  assign wa    = bus.we & (~full_q | bus.re);
  assign ra    = bus.re & ~empty_q;

  always_comb begin
    cnt_nxt = cnt;
    if (wa && !ra)      cnt_nxt = cnt + CW'(1);
    else if (ra && !wa) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wa) wp <= wp + AW'(1);
      if (ra) rp <= rp + AW'(1);
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(DEPTH));
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= CW'(AF_LEVEL));
      ae_q    <= (cnt_nxt <= CW'(AE_LEVEL));
      if (bus.we && full_q && !bus.re) ovf_q <= 1'b1;
      if (bus.re && empty_q)           udf_q <= 1'b1;
    end
  end

  sc_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wa && !flush),
    .wr_addr (wp),
    .wr_data (bus.din),
    .rd_addr (rp),
    .rd_data (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign bus.dout = rd_data;
  end else begin : g_reg_read
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (flush)   dout_q <= '0;
      else if (ra) dout_q <= rd_data;
    end
    assign bus.dout = dout_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sc_fifo_param.sv
// Bench for sc_fifo_param: registered-read and FWFT instances share one stimulus stream.
module tb_sc_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  sc_fifo_param_if #(.DW(8), .AW(3)) b0 ();
  sc_fifo_param_if #(.DW(8), .AW(3)) b1 ();

  assign b0.din = din;
  assign b0.we  = we;
  assign b0.re  = re;
  assign b1.din = din;
  assign b1.we  = we;
  assign b1.re  = re;

  sc_fifo_param #(.DW(8), .AW(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk (clk), .rst (rst), .clr (clr), .bus (b0.slave)
  );
  sc_fifo_param #(.DW(8), .AW(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk (clk), .rst (rst), .clr (clr), .bus (b1.slave)
  );

  // behavioural model: a queue of stored words plus the last registered read word
  logic [7:0] exp_q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;
  bit         m_full, m_empty;

  always @(posedge clk) begin
    if (!rst || clr) begin
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_full  = (exp_q.size() == 8);
      m_empty = (exp_q.size() == 0);
      if (we && m_full && !re) m_ovf = 1'b1;
      if (re && m_empty)       m_udf = 1'b1;
      if (re && !m_empty)      m_dout = exp_q.pop_front();
      if (we && (!m_full || re)) exp_q.push_back(din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("count0", 32'(b0.count), 32'(exp_q.size()));
      check("count1", 32'(b1.count), 32'(exp_q.size()));
      check("full0",  32'(b0.full),  32'(exp_q.size() == 8));
      check("full1",  32'(b1.full),  32'(exp_q.size() == 8));
      check("empty0", 32'(b0.empty), 32'(exp_q.size() == 0));
      check("empty1", 32'(b1.empty), 32'(exp_q.size() == 0));
      check("afull0", 32'(b0.almost_full),  32'(exp_q.size() >= 6));
      check("afull1", 32'(b1.almost_full),  32'(exp_q.size() >= 6));
      check("aempty0", 32'(b0.almost_empty), 32'(exp_q.size() <= 2));
      check("aempty1", 32'(b1.almost_empty), 32'(exp_q.size() <= 2));
      check("ovf0", 32'(b0.overflow),  32'(m_ovf));
      check("ovf1", 32'(b1.overflow),  32'(m_ovf));
      check("udf0", 32'(b0.underflow), 32'(m_udf));
      check("udf1", 32'(b1.underflow), 32'(m_udf));
      check("dout0", 32'(b0.dout), 32'(m_dout));
      if (exp_q.size() > 0) check("dout1", 32'(b1.dout), 32'(exp_q[0]));
    end
  end

  // driver: inputs change on the falling edge and hold across the next rising edge
  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    we  = w;
    re  = r;
    din = d;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(b0.count), 32'd0);
    check({tag, "_empty"},  32'(b0.empty), 32'd1);
    check({tag, "_aempty"}, 32'(b0.almost_empty), 32'd1);
    check({tag, "_full"},   32'(b0.full), 32'd0);
    check({tag, "_afull"},  32'(b0.almost_full), 32'd0);
    check({tag, "_ovf"},    32'(b0.overflow), 32'd0);
    check({tag, "_udf"},    32'(b0.underflow), 32'd0);
    check({tag, "_dout"},   32'(b0.dout), 32'd0);
  endtask

  initial begin
    int pw, pr;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check_reset_state("rst");
    rst = 1'b1;

    // fill 0x01..0x08 and watch the threshold flags move
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      if (i == 2) check("ae_after2", 32'(b0.almost_empty), 32'd1);
      if (i == 3) check("ae_after3", 32'(b0.almost_empty), 32'd0);
      if (i == 5) check("af_after5", 32'(b0.almost_full), 32'd0);
      if (i == 6) check("af_after6", 32'(b0.almost_full), 32'd1);
    end
    check("full_after8", 32'(b0.full), 32'd1);
    check("count_after8", 32'(b0.count), 32'd8);

    drive(1'b1, 1'b0, 8'hAA);
    check("ovf_set", 32'(b0.overflow), 32'd1);
    check("count_ovf", 32'(b0.count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      check("drain_dout", 32'(b0.dout), 32'(i));
    end
    check("empty_drained", 32'(b0.empty), 32'd1);

    // simultaneous read/write while full
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h11 + i));
    drive(1'b1, 1'b1, 8'h55);
    check("rw_full_count", 32'(b0.count), 32'd8);
    check("rw_full_full", 32'(b0.full), 32'd1);
    check("rw_full_pop", 32'(b0.dout), 32'h11);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      check("wrap_dout", 32'(b0.dout), (i == 7) ? 32'h55 : 32'(8'h12 + i));
    end

    // read+write while empty: read dropped, write taken
    drive(1'b1, 1'b1, 8'h33);
    check("uf_udf", 32'(b0.underflow), 32'd1);
    check("uf_count", 32'(b0.count), 32'd1);
    check("uf_empty", 32'(b0.empty), 32'd0);
    check("uf_fwft_dout", 32'(b1.dout), 32'h33);

    // reset mid-operation at count 5
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h60 + i));
    check("count5", 32'(b0.count), 32'd5);
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h77);
    rst = 1'b1;
    check_reset_state("midrst");

    // clear from full with overflow set
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'(8'h80 + i));
    check("pre_clr_ovf", 32'(b0.overflow), 32'd1);
    check("pre_clr_full", 32'(b0.full), 32'd1);
    clr = 1'b1;
    drive(1'b1, 1'b1, 8'h99);
    clr = 1'b0;
    check_reset_state("clr");
    drive(1'b1, 1'b0, 8'h42);
    check("post_clr_count", 32'(b0.count), 32'd1);
    check("post_clr_fwft", 32'(b1.dout), 32'h42);

    // randomized traffic with phases biased toward filling, draining and balance
    for (int n = 0; n < 3000; n++) begin
      case ((n / 150) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) != 0);
      drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom_range(0, 255)));
    end
    clr = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_fifo_param.md
SC_FIFO_PARAM -- requirements
Module: sc_fifo_param

Interface
REQ-001 SHALL have parameter DW, default 61, data width in bits (>=1).
REQ-002 SHALL have parameter AW, default 3, address width; depth = 2^AW entries (AW>=1).
REQ-003 SHALL have parameter AF_LEVEL, default 6, almost-full threshold, legal range 1..2^AW.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold, legal range 0..2^AW-1.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port clr  in  1  synchronous clear, active-high.
REQ-009 SHALL have port din  in  DW  write data.
REQ-010 SHALL have port we  in  1  write request.
REQ-011 SHALL have port re  in  1  read request.
REQ-012 SHALL have port dout  out  DW  read data.
REQ-013 SHALL have port full  out  1  registered, count == 2^AW.
REQ-014 SHALL have port empty  out  1  registered, count == 0.
REQ-015 SHALL have port almost_full  out  1  registered, count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  out  1  registered, count <= AE_LEVEL.
REQ-017 SHALL have port count  out  AW+1  registered occupancy, 0..2^AW.
REQ-018 SHALL have port overflow  out  1  sticky, write attempted while full.
REQ-019 SHALL have port underflow  out  1  sticky, read attempted while empty.

Function
REQ-020 Write accepted (wa) = we & (!full | re); read accepted (ra) = re & !empty; SHALL evaluate both from registered flags only.
REQ-021 On wa: mem[wp] <= din, wp <= wp+1 modulo 2^AW; on ra: rp <= rp+1 modulo 2^AW; wrap SHALL be silent.
REQ-022 count SHALL update: +1 on wa&!ra, -1 on ra&!wa, unchanged otherwise; never exceed 2^AW or go below 0.
REQ-023 All four flags SHALL be computed from next-count and registered, so they reflect the operation at the very next clock edge (Tcq output delay only).
REQ-024 we & full & !re SHALL be dropped (no pointer/count/memory change) and set overflow.
REQ-025 re & empty SHALL be dropped and set underflow; with we also high, the write is still accepted.
REQ-026 we & re while full SHALL accept both; count stays 2^AW; full stays 1.
REQ-027 FWFT=0: on ra, dout SHALL register mem[rp] at that edge (1-cycle latency); otherwise dout holds.
REQ-028 FWFT=1: dout SHALL equal mem[rp] combinationally, valid whenever empty=0; first write into empty FIFO SHALL deassert empty and present data at the next edge.
REQ-029 overflow/underflow SHALL remain set until rst or clr.
REQ-030 clr SHALL behave as reset (REQ-031) except it has lower priority than rst.

Reset
REQ-031 On rst=0 at a clock edge: wp=rp=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, dout=0 (FWFT=0); memory contents SHALL NOT be cleared.
REQ-032 Reset or clr mid-operation SHALL discard all stored entries and any same-cycle we/re.

Structure
REQ-033 Shared package sc_fifo_pkg SHALL hold default parameter constants and the count-width function (AW+1).
REQ-034 Storage SHALL be one sub-module sc_fifo_ram: 2^AW x DW, one synchronous write port, one asynchronous read port.
REQ-035 Illegal AF_LEVEL/AE_LEVEL SHALL be rejected at elaboration.

Verification (DW=8, AW=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-036 Reset then 8 writes 0x01..0x08 -> almost_empty drops after 3rd, almost_full rises after 6th, full=1 and count=8 after 8th.
REQ-037 Full, we=1 re=0 din=0xAA -> overflow=1, count=8; subsequent 8 reads (FWFT=0) return 0x01..0x08 one cycle after each re.
REQ-038 Full, we=re=1 din=0x55 -> count=8, full=1, oldest entry popped, 0x55 read last after wrap.
REQ-039 Empty, re=1 we=1 din=0x33 -> underflow=1, count=1, empty=0 next edge; FWFT=1 dout=0x33 same cycle empty falls.
REQ-040 Count=5 with rst=0 one cycle -> all flags/count/errors at reset values; clr=1 likewise from full with overflow=1.
